cluster_icache_flush_sequencer: RTL and testbench



---
 rtl/cluster_icache_flush_pkg.sv | 21 ++
 rtl/cluster_icache_flush_watchdog.sv | 41 ++++
 rtl/cluster_icache_flush_sequencer.sv | 111 +++++++++++
 tb/tb_cluster_icache_flush_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cluster_icache_flush_pkg.sv
// Shared types for the icache flush sequencer: FSM state encoding and the flush command.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cluster_icache_flush_pkg;

    // Widest supported fetch-port count; the latched L0 mask is stored at this width.
    localparam int unsigned MAX_FETCH_PORTS = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH_L1 = 2'd1,
        FLUSH_L0 = 2'd2,
        DONE     = 2'd3
    } flush_state_e;

    typedef struct packed {
        logic [MAX_FETCH_PORTS-1:0] l0_mask;
        logic                       l1;
    } flush_cmd_t;

endpackage

// File: rtl/cluster_icache_flush_watchdog.sv
// Watchdog for a flush in progress: counts active cycles and raises a sticky timeout flag.
// Latency: flag rises on the edge where the counter reaches TIMEOUT_CYCLES; counter saturates there.
// Backpressure: none; observes only, never stalls or alters the flush handshakes.
module cluster_icache_flush_watchdog
    import cluster_icache_flush_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic count_en_i,
    output logic timeout_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic             flag_q;

    // Count active cycles up to LIMIT; a new command restarts the count and drops the flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else if (clear_i) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else if (count_en_i && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + ONE;
            if ((cnt_q + ONE) == LIMIT) begin
                flag_q <= 1'b1;
            end
        end
    end

    assign timeout_o = flag_q;

endmodule

// File: rtl/cluster_icache_flush_sequencer.sv
// Sequences one icache flush command: L1 first, then all selected L0 caches in parallel.
// Latency: accept N, L1 hs N+1, L0 hs N+2, done_o N+3, ready N+4 (one cycle less without L1).
// Backpressure: req_ready_o only in IDLE; each target valid held until its ready. Watchdog: CLUSTER_ICACHE_FLUSH_TIMEOUT_EN.
module cluster_icache_flush_sequencer
    import cluster_icache_flush_pkg::*;
#(
    parameter int unsigned NR_FETCH_PORTS = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [NR_FETCH_PORTS-1:0] req_l0_mask_i,
    input  logic                      req_l1_i,
    output logic                      l1_flush_valid_o,
    input  logic                      l1_flush_ready_i,
    output logic [NR_FETCH_PORTS-1:0] l0_flush_valid_o,
    input  logic [NR_FETCH_PORTS-1:0] l0_flush_ready_i,
    output logic                      busy_o,
    output logic [NR_FETCH_PORTS-1:0] pending_o,
    output logic                      done_o,
    output logic                      timeout_o
);

    flush_state_e state_q;
    flush_cmd_t   cmd_q;

    logic                       accept;
    logic                       l1_hs;
    logic [MAX_FETCH_PORTS-1:0] req_mask_ext;
    logic [MAX_FETCH_PORTS-1:0] l0_hs;
    logic [MAX_FETCH_PORTS-1:0] pend_next;

    assign accept       = req_valid_i & (state_q == IDLE);
    assign req_mask_ext = MAX_FETCH_PORTS'(req_l0_mask_i);
    assign l1_hs        = l1_flush_valid_o & l1_flush_ready_i;
    // Ready on a port whose valid is low never counts, since valid gates the handshake.
    assign l0_hs        = MAX_FETCH_PORTS'(l0_flush_valid_o & l0_flush_ready_i);
    assign pend_next    = cmd_q.l0_mask & ~l0_hs;

    // Flush FSM: latch the command on acceptance, then retire L1 and the pending L0 bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cmd_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        cmd_q.l0_mask <= req_mask_ext;
                        cmd_q.l1      <= req_l1_i;
                        if (req_l1_i) begin
                            state_q <= FLUSH_L1;
                        end else if (req_mask_ext != '0) begin
                            state_q <= FLUSH_L0;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                FLUSH_L1: begin
                    if (l1_hs) begin
                        cmd_q.l1 <= 1'b0;
                        state_q  <= (cmd_q.l0_mask != '0) ? FLUSH_L0 : DONE;
                    end
                end
                FLUSH_L0: begin
                    cmd_q.l0_mask <= pend_next;
                    if (pend_next == '0) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    cmd_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    cmd_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Every output is a pure decode of the registered state and pending bits.
    assign req_ready_o      = (state_q == IDLE);
    assign l1_flush_valid_o = (state_q == FLUSH_L1) & cmd_q.l1;
    assign l0_flush_valid_o = (state_q == FLUSH_L0) ? cmd_q.l0_mask[NR_FETCH_PORTS-1:0] : '0;
    assign busy_o           = (state_q != IDLE);
    assign pending_o        = cmd_q.l0_mask[NR_FETCH_PORTS-1:0];
    assign done_o           = (state_q == DONE);

`ifdef CLUSTER_ICACHE_FLUSH_TIMEOUT_EN
    cluster_icache_flush_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (accept),
        .count_en_i ((state_q == FLUSH_L1) || (state_q == FLUSH_L0)),
        .timeout_o  (timeout_o)
    );
`else
    // Watchdog absent: the limit parameter and acceptance strobe have no consumer.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES < 2) ^ accept;
    assign timeout_o          = 1'b0;
`endif

endmodule

// File: tb/tb_cluster_icache_flush_sequencer.sv
module tb_cluster_icache_flush_sequencer;

    localparam int NP = 4;
    localparam int TO = 8;
`ifdef CLUSTER_ICACHE_FLUSH_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [NP-1:0] req_mask;
    logic          req_l1;
    logic          l1_vld;
    logic          l1_rdy;
    logic [NP-1:0] l0_vld;
    logic [NP-1:0] l0_rdy;
    logic          busy;
    logic [NP-1:0] pending;
    logic          done;
    logic          timeout;

    cluster_icache_flush_sequencer #(
        .NR_FETCH_PORTS (NP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_l0_mask_i    (req_mask),
        .req_l1_i         (req_l1),
        .l1_flush_valid_o (l1_vld),
        .l1_flush_ready_i (l1_rdy),
        .l0_flush_valid_o (l0_vld),
        .l0_flush_ready_i (l0_rdy),
        .busy_o           (busy),
        .pending_o        (pending),
        .done_o           (done),
        .timeout_o        (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Output snapshot: {req_ready, l1_vld, l0_vld[3:0], busy, pending[3:0], done, timeout}
    typedef struct {
        int          cyc;
        logic [12:0] v;
    } snap_t;

    typedef struct {
        int         cyc;
        logic [3:0] l0;
        logic       l1;
    } comp_t;

    snap_t snapq[$];
    comp_t compq[$];

    function automatic void expect_at(int c, logic rr, logic l1v, logic [3:0] l0v,
                                      logic bsy, logic [3:0] pend, logic dn, logic to);
        snap_t s;
        s.cyc = c;
        s.v   = {rr, l1v, l0v, bsy, pend, dn, to};
        snapq.push_back(s);
    endfunction

    function automatic void expect_idle(int c, logic to);
        expect_at(c, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, to);
    endfunction

    function automatic void expect_done(int c, logic [3:0] l0, logic l1);
        comp_t e;
        e.cyc = c;
        e.l0  = l0;
        e.l1  = l1;
        compq.push_back(e);
    endfunction

    // Monitor: compare queued snapshots in their cycle; check each completion against observed handshakes.
    logic [3:0] acc_l0 = 4'b0000;
    logic       acc_l1 = 1'b0;
    always @(negedge clk) begin
        logic [12:0] act;
        snap_t       s;
        comp_t       c;
        act = {req_ready, l1_vld, l0_vld, busy, pending, done, timeout};
        while (snapq.size() > 0 && snapq[0].cyc <= cyc) begin
            s = snapq.pop_front();
            checks++;
            if (s.cyc < cyc) begin
                errors++;
                $display("FAIL snapshot_missed cyc=%0d required=%h", s.cyc, s.v);
            end else if (act !== s.v) begin
                errors++;
                $display("FAIL snapshot cyc=%0d actual=%h required=%h", cyc, act, s.v);
            end
        end
        if (rst) begin
            acc_l0 = 4'b0000;
            acc_l1 = 1'b0;
        end else begin
            if (l1_vld === 1'b1 && l1_rdy === 1'b1) acc_l1 = 1'b1;
            acc_l0 = acc_l0 | (l0_vld & l0_rdy);
            if (done === 1'b1) begin
                checks++;
                if (compq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done cyc=%0d actual=1 required=0", cyc);
                end else begin
                    c = compq.pop_front();
                    if (c.cyc != cyc || c.l0 !== acc_l0 || c.l1 !== acc_l1) begin
                        errors++;
                        $display("FAIL completion cyc=%0d l0=%b l1=%b required cyc=%0d l0=%b l1=%b",
                                 cyc, acc_l0, acc_l1, c.cyc, c.l0, c.l1);
                    end
                end
                acc_l0 = 4'b0000;
                acc_l1 = 1'b0;
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int b;

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_mask  = 4'b0000;
        req_l1    = 1'b0;
        l1_rdy    = 1'b0;
        l0_rdy    = 4'b0000;
        tick(2);

        // Reset state
        rst = 1'b0;
        b   = cyc;
        expect_idle(b, 1'b0);
        expect_idle(b + 1, 1'b0);
        tick(2);

        // Basic L1 + L0 with all readies high
        b         = cyc;
        l1_rdy    = 1'b1;
        l0_rdy    = 4'b1111;
        req_valid = 1'b1;
        req_mask  = 4'b1010;
        req_l1    = 1'b1;
        expect_idle(b, 1'b0);
        expect_at(b + 1, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b1010, 1'b0, 1'b0);
        expect_at(b + 2, 1'b0, 1'b0, 4'b1010, 1'b1, 4'b1010, 1'b0, 1'b0);
        expect_at(b + 3, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);
        expect_idle(b + 4, 1'b0);
        expect_done(b + 3, 4'b1010, 1'b1);
        tick(1);
        req_valid = 1'b0;
        tick(4);

        // Staggered L0 completion, L1 ready high but ignored
        b         = cyc;
        l0_rdy    = 4'b0000;
        req_valid = 1'b1;
        req_mask  = 4'b1111;
        req_l1    = 1'b0;
        expect_idle(b, 1'b0);
        for (int k = 1; k <= 2; k++)
            expect_at(b + k, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b1111, 1'b0, 1'b0);
        for (int k = 3; k <= 5; k++)
            expect_at(b + k, 1'b0, 1'b0, 4'b1110, 1'b1, 4'b1110, 1'b0, 1'b0);
        expect_at(b + 6, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);
        expect_idle(b + 7, 1'b0);
        expect_done(b + 6, 4'b1111, 1'b0);
        tick(1);
        req_valid = 1'b0;
        tick(1);
        l0_rdy = 4'b0001;
        tick(1);
        l0_rdy = 4'b0000;
        tick(2);
        l0_rdy = 4'b1110;
        tick(3);
        l0_rdy = 4'b0000;

        // No-op command
        b         = cyc;
        req_valid = 1'b1;
        req_mask  = 4'b0000;
        req_l1    = 1'b0;
        expect_idle(b, 1'b0);
        expect_at(b + 1, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);
        expect_idle(b + 2, 1'b0);
        expect_done(b + 1, 4'b0000, 1'b0);
        tick(1);
        req_valid = 1'b0;
        tick(2);

        // Busy rejection: second request held during FLUSH_L0, accepted after DONE
        b         = cyc;
        req_valid = 1'b1;
        req_mask  = 4'b0011;
        req_l1    = 1'b0;
        expect_idle(b, 1'b0);
        expect_at(b + 1, 1'b0, 1'b0, 4'b0011, 1'b1, 4'b0011, 1'b0, 1'b0);
        expect_at(b + 2, 1'b0, 1'b0, 4'b0011, 1'b1, 4'b0011, 1'b0, 1'b0);
        expect_at(b + 3, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);
        expect_idle(b + 4, 1'b0);
        expect_at(b + 5, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0, 1'b0);
        expect_at(b + 6, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);
        expect_idle(b + 7, 1'b0);
        expect_done(b + 3, 4'b0011, 1'b0);
        expect_done(b + 6, 4'b0001, 1'b0);
        tick(1);
        req_mask = 4'b0001;
        tick(1);
        l0_rdy = 4'b0011;
        tick(3);
        req_valid = 1'b0;
        tick(3);
        l0_rdy = 4'b0000;

        // Reset mid-flush while pending=0110 in FLUSH_L0; no completion follows
        b         = cyc;
        l1_rdy    = 1'b1;
        req_valid = 1'b1;
        req_mask  = 4'b0110;
        req_l1    = 1'b1;
        expect_idle(b, 1'b0);
        expect_at(b + 1, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0110, 1'b0, 1'b0);
        expect_at(b + 2, 1'b0, 1'b0, 4'b0110, 1'b1, 4'b0110, 1'b0, 1'b0);
        expect_idle(b + 3, 1'b0);
        expect_idle(b + 4, 1'b0);
        tick(1);
        req_valid = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);

        // Stalled L1 flush: watchdog (when built in) fires after 8 active cycles, clears on next accept
        b         = cyc;
        l1_rdy    = 1'b0;
        l0_rdy    = 4'b1111;
        req_valid = 1'b1;
        req_mask  = 4'b0001;
        req_l1    = 1'b1;
        expect_idle(b, 1'b0);
        for (int k = 1; k <= 8; k++)
            expect_at(b + k, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0);
        expect_at(b + 9, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0001, 1'b0, TO_EN);
        expect_at(b + 10, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0, TO_EN);
        expect_at(b + 11, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, TO_EN);
        expect_idle(b + 12, TO_EN);
        expect_at(b + 13, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);
        expect_idle(b + 14, 1'b0);
        expect_done(b + 11, 4'b0001, 1'b1);
        expect_done(b + 13, 4'b0000, 1'b0);
        tick(1);
        req_valid = 1'b0;
        tick(8);
        l1_rdy = 1'b1;
        tick(3);
        req_valid = 1'b1;
        req_mask  = 4'b0000;
        req_l1    = 1'b0;
        tick(1);
        req_valid = 1'b0;
        tick(3);

        // Every scheduled expectation must have been consumed
        checks++;
        if (snapq.size() != 0) begin
            errors++;
            $display("FAIL snapshots_left actual=%0d required=0", snapq.size());
        end
        checks++;
        if (compq.size() != 0) begin
            errors++;
            $display("FAIL completions_left actual=%0d required=0", compq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
